// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: multi-cycle a - b, one 4-bit carry-lookahead slice per clock, LSB nibble first.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int N  = WIDTH / 4;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, nb_q, diff_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q, borrow_q, ovf_q, out_valid_q;
    logic [3:0]       x, y, p, g, s;
    logic [4:0]       c;
    logic             last;
    assign x    = a_q[{idx_q, 2'b00} +: 4];
    assign y    = nb_q[{idx_q, 2'b00} +: 4];
    assign p    = x ^ y;
    assign g    = x & y;
    assign c[0] = carry_q;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign s    = p ^ c[3:0];
    assign last = idx_q == IW'(N - 1);
    assign in_ready   = (state_q == IDLE) & ~reset;
    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            a_q         <= '0;
            nb_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    nb_q    <= ~b;
                    carry_q <= 1'b1;
                    idx_q   <= '0;
                    state_q <= BUSY;
                end
                BUSY: begin
                    diff_q[{idx_q, 2'b00} +: 4] <= s;
                    carry_q <= c[4];
                    // c[3] on the top slice is the carry into the word's sign bit
                    if (last) begin
                        borrow_q    <= ~c[4];
                        ovf_q       <= c[3] ^ c[4];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
